// File: rtl/pio_led_driver_pkg.sv
// Shared types and helpers for the PIO LED fader.
// Optional build macro: PIO_LED_DRIVER_GAMMA_EN (selects the perceptual duty-to-level map).
package pio_led_driver_pkg;

  localparam int DUTY_W = 8;

  typedef logic [DUTY_W-1:0] duty_t;

  localparam duty_t DUTY_MAX = 8'd255;

  // Perceptual brightness map: level = (duty * duty) >> 8.
  function automatic duty_t gamma_map(input duty_t d);
    logic [2*DUTY_W-1:0] sq;
    sq = {8'd0, d} * {8'd0, d};
    return sq[2*DUTY_W-1:DUTY_W];
  endfunction

endpackage

// File: rtl/pio_led_channel.sv
// One LED channel: saturating duty ramp toward the target bit, level mapping,
// and the registered PWM compare. Solid on/off at the duty end points.
// Optional build macro: PIO_LED_DRIVER_GAMMA_EN (level = gamma_map(duty)).
module pio_led_channel
  import pio_led_driver_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  i_ctrl_q,
  input  logic  i_ramp_tick,
  input  duty_t i_pwm_cnt,
  output logic  o_led,
  output logic  o_busy
);

  duty_t r_duty;
  logic  r_led;
  duty_t w_duty_nxt;
  duty_t w_level;
  logic  w_led_nxt;

`ifdef PIO_LED_DRIVER_GAMMA_EN
  assign w_level = gamma_map(r_duty);
`else
  assign w_level = r_duty;
`endif

  // Step the duty one count toward the target on each ramp tick, saturating at the ends.
  always_comb begin
    w_duty_nxt = r_duty;
    if (i_ramp_tick) begin
      if (i_ctrl_q) begin
        if (r_duty != DUTY_MAX) begin
          w_duty_nxt = r_duty + 8'd1;
        end else begin
          w_duty_nxt = r_duty;
        end
      end else begin
        if (r_duty != 8'd0) begin
          w_duty_nxt = r_duty - 8'd1;
        end else begin
          w_duty_nxt = r_duty;
        end
      end
    end else begin
      w_duty_nxt = r_duty;
    end
  end

  // PWM compare on the current (pre-update) duty; the end points override the compare.
  always_comb begin
    w_led_nxt = 1'b0;
    if (r_duty == DUTY_MAX) begin
      w_led_nxt = 1'b1;
    end else if (r_duty == 8'd0) begin
      w_led_nxt = 1'b0;
    end else begin
      w_led_nxt = (i_pwm_cnt < w_level);
    end
  end

  // Duty and LED pin registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_duty <= 8'd0;
      r_led  <= 1'b0;
    end else begin
      r_duty <= w_duty_nxt;
      r_led  <= w_led_nxt;
    end
  end

  assign o_led  = r_led;
  assign o_busy = i_ctrl_q ? (r_duty != DUTY_MAX) : (r_duty != 8'd0);

endmodule

// File: rtl/pio_led_driver.sv
// Per-channel LED fader driven by the PIO control word. Registers the
// control word, runs the shared ramp/PWM prescalers and the 8-bit PWM
// counter, and instantiates one pio_led_channel per bit.
// Optional build macro: PIO_LED_DRIVER_GAMMA_EN (perceptual fade curve).
module pio_led_driver
  import pio_led_driver_pkg::*;
#(
  parameter int CH       = 4,
  parameter int PWM_DIV  = 8,
  parameter int RAMP_DIV = 50000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CH-1:0] ctrl,
  output logic [CH-1:0] led,
  output logic [CH-1:0] busy
);

  localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int PWM_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  localparam logic [PWM_W-1:0]  PWM_LAST  = PWM_W'(PWM_DIV - 1);

  logic [CH-1:0]     r_ctrl_q;
  logic [RAMP_W-1:0] r_ramp_cnt;
  logic [PWM_W-1:0]  r_pwm_pre;
  duty_t             r_pwm_cnt;
  logic              w_ramp_tick;
  logic              w_pwm_tick;

  assign w_ramp_tick = (r_ramp_cnt == RAMP_LAST);
  assign w_pwm_tick  = (r_pwm_pre == PWM_LAST);

  // Input stage: capture the PIO control word once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl_q <= '0;
    end else begin
      r_ctrl_q <= ctrl;
    end
  end

  // Ramp prescaler: 0..RAMP_DIV-1, tick on the last count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ramp_cnt <= '0;
    end else if (w_ramp_tick) begin
      r_ramp_cnt <= '0;
    end else begin
      r_ramp_cnt <= r_ramp_cnt + RAMP_W'(1);
    end
  end

  // PWM prescaler: 0..PWM_DIV-1, tick on the last count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_pre <= '0;
    end else if (w_pwm_tick) begin
      r_pwm_pre <= '0;
    end else begin
      r_pwm_pre <= r_pwm_pre + PWM_W'(1);
    end
  end

  // PWM counter: free-running 8-bit, advances on each prescaler tick and wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= 8'd0;
    end else if (w_pwm_tick) begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end else begin
      r_pwm_cnt <= r_pwm_cnt;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    pio_led_channel u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_ctrl_q    (r_ctrl_q[g]),
      .i_ramp_tick (w_ramp_tick),
      .i_pwm_cnt   (r_pwm_cnt),
      .o_led       (led[g]),
      .o_busy      (busy[g])
    );
  end

endmodule

// File: tb/tb_pio_led_driver.sv
// Directed bench for pio_led_driver. A fast instance (RAMP_DIV=4, PWM_DIV=1)
// covers reset, ramps, reversal and mid-ramp reset; a slow instance
// (RAMP_DIV=256, PWM_DIV=1) holds each duty for a full PWM period so the
// high time can be counted. Edge numbers count posedges since reset release.
module tb_pio_led_driver;

  logic       clk = 1'b0;
  logic       reset_n, reset_n_s;
  logic [3:0] ctrl, ctrl_s;
  logic [3:0] led, busy, led_s, busy_s;

  int total = 0;
  int bad   = 0;
  int cur   = 0;

`ifdef PIO_LED_DRIVER_GAMMA_EN
  localparam bit GAM = 1'b1;
`else
  localparam bit GAM = 1'b0;
`endif

  always #5 clk = ~clk;

  pio_led_driver #(.CH(4), .PWM_DIV(1), .RAMP_DIV(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .ctrl(ctrl), .led(led), .busy(busy)
  );

  pio_led_driver #(.CH(4), .PWM_DIV(1), .RAMP_DIV(256)) u_slow (
    .clk(clk), .reset_n(reset_n_s), .ctrl(ctrl_s), .led(led_s), .busy(busy_s)
  );

  typedef struct {
    int         at_edge;
    logic [3:0] led_lin;
    logic [3:0] led_gam;
    logic [3:0] busy;
  } ramp_vec_t;

  typedef struct {
    int duty;
    int hi_lin;
    int hi_gam;
  } pwm_vec_t;

  ramp_vec_t ramp_tab [14];
  pwm_vec_t  pwm_tab  [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the negedge that follows posedge number t.
  task automatic step_to(input int t);
    while (cur < t) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic do_reset(input logic [3:0] c);
    @(negedge clk);
    reset_n = 1'b0;
    ctrl    = c;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cur     = 0;
  endtask

  initial begin
    int errs;
    int hi;

    ramp_tab[0]  = '{1,    4'b0000, 4'b0000, 4'b0001};
    ramp_tab[1]  = '{4,    4'b0000, 4'b0000, 4'b0001};
    ramp_tab[2]  = '{5,    4'b0000, 4'b0000, 4'b0001};
    ramp_tab[3]  = '{257,  4'b0001, 4'b0001, 4'b0001};
    ramp_tab[4]  = '{321,  4'b0001, 4'b0000, 4'b0001};
    ramp_tab[5]  = '{337,  4'b0001, 4'b0000, 4'b0001};
    ramp_tab[6]  = '{341,  4'b0001, 4'b0000, 4'b0001};
    ramp_tab[7]  = '{345,  4'b0000, 4'b0000, 4'b0001};
    ramp_tab[8]  = '{600,  4'b0001, 4'b0000, 4'b0001};
    ramp_tab[9]  = '{700,  4'b0000, 4'b0000, 4'b0001};
    ramp_tab[10] = '{1019, 4'b0001, 4'b0001, 4'b0001};
    ramp_tab[11] = '{1020, 4'b0001, 4'b0001, 4'b0000};
    ramp_tab[12] = '{1021, 4'b0001, 4'b0001, 4'b0000};
    ramp_tab[13] = '{1024, 4'b0001, 4'b0001, 4'b0000};

    pwm_tab[0] = '{16,  16,  1};
    pwm_tab[1] = '{64,  64,  16};
    pwm_tab[2] = '{128, 128, 64};
    pwm_tab[3] = '{160, 160, 100};

    reset_n   = 1'b0;
    reset_n_s = 1'b0;
    ctrl      = 4'b0000;
    ctrl_s    = 4'b0001;

    // Reset state and idle hold.
    repeat (3) @(negedge clk);
    check("rst_led", {28'd0, led}, 32'd0);
    check("rst_busy", {28'd0, busy}, 32'd0);
    reset_n = 1'b1;
    cur     = 0;
    errs    = 0;
    for (int i = 0; i < 2000; i++) begin
      step_to(cur + 1);
      if (led !== 4'b0000 || busy !== 4'b0000) errs++;
    end
    check("idle_hold_errs", errs, 32'd0);

    // Full ramp-up on channel 0, checkpoints from the table.
    do_reset(4'b0001);
    for (int i = 0; i < 14; i++) begin
      step_to(ramp_tab[i].at_edge);
      check($sformatf("ramp_led@%0d", ramp_tab[i].at_edge), {28'd0, led},
            {28'd0, (GAM ? ramp_tab[i].led_gam : ramp_tab[i].led_lin)});
      check($sformatf("ramp_busy@%0d", ramp_tab[i].at_edge), {28'd0, busy},
            {28'd0, ramp_tab[i].busy});
    end
    errs = 0;
    for (int i = 0; i < 276; i++) begin
      step_to(cur + 1);
      if (led !== 4'b0001 || busy !== 4'b0000) errs++;
    end
    check("solid_on_errs", errs, 32'd0);

    // Reversal at duty 100: falls back to 0 in exactly 100 ticks.
    do_reset(4'b0001);
    step_to(400);
    ctrl = 4'b0000;
    step_to(401);
    check("rev_busy_start", {28'd0, busy}, 32'd1);
    step_to(799);
    check("rev_busy_last", {28'd0, busy}, 32'd1);
    step_to(800);
    check("rev_busy_done", {28'd0, busy}, 32'd0);
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      step_to(cur + 1);
      if (led !== 4'b0000 || busy !== 4'b0000) errs++;
    end
    check("solid_off_errs", errs, 32'd0);

    // Reset mid-ramp (duty 150) then all channels ramp together.
    do_reset(4'b1111);
    step_to(600);
    check("mid_busy_pre", {28'd0, busy}, 32'hF);
    reset_n = 1'b0;
    #1;
    check("mid_rst_led", {28'd0, led}, 32'd0);
    check("mid_rst_busy", {28'd0, busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cur     = 0;
    step_to(1);
    check("all_busy_start", {28'd0, busy}, 32'hF);
    check("all_led_start", {28'd0, led}, 32'd0);
    step_to(257);
    check("all_led_257", {28'd0, led}, 32'hF);
    step_to(1019);
    check("all_busy_1019", {28'd0, busy}, 32'hF);
    step_to(1020);
    check("all_busy_done", {28'd0, busy}, 32'd0);
    step_to(1024);
    check("all_led_solid", {28'd0, led}, 32'hF);

    // PWM high time per 256-cycle period on the slow instance.
    @(negedge clk);
    reset_n_s = 1'b1;
    cur       = 0;
    for (int i = 0; i < 4; i++) begin
      step_to(256 * pwm_tab[i].duty);
      hi   = 0;
      errs = 0;
      for (int k = 0; k < 256; k++) begin
        step_to(cur + 1);
        if (led_s[0] === 1'b1) hi++;
        if (led_s[3:1] !== 3'b000 || busy_s !== 4'b0001) errs++;
      end
      check($sformatf("pwm_hi_duty%0d", pwm_tab[i].duty), hi,
            GAM ? pwm_tab[i].hi_gam : pwm_tab[i].hi_lin);
      check($sformatf("pwm_side_duty%0d", pwm_tab[i].duty), errs, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pio_led_driver.md
# pio_led_driver

Per-channel LED fader that consumes the 4-bit control word driven by the Avalon PIO output register (`out_port`). Each control bit sets a channel's target: 1 is fully on, 0 is off. The block ramps an 8-bit duty value toward that target at a fixed rate and drives the LED pins with PWM. Software therefore sees soft on/off transitions without doing any timing itself. Same `clk` domain as the PIO.

## Interface
Parameters:
- `CH`, 4 — number of channels; matches the PIO width.
- `PWM_DIV`, 8 — clk cycles per PWM counter step; minimum 1.
- `RAMP_DIV`, 50000 — clk cycles per duty step; minimum 1.

Ports:
- `clk`  in  1  — clock.
- `reset_n`  in  1  — reset, asynchronous, active-low.
- `ctrl`  in  CH  — target per channel, from the PIO `out_port`.
- `led`  out  CH  — PWM LED drive, active-high, registered.
- `busy`  out  CH  — channel is ramping (duty ≠ target).

## Operation
Input stage:
- `ctrl` is registered once into `ctrl_q`.
- All internal logic uses `ctrl_q`.

Prescalers (shared by all channels):
- `ramp_cnt` counts 0..RAMP_DIV-1 and wraps. `ramp_tick` is asserted when `ramp_cnt` = RAMP_DIV-1.
- `pwm_pre` counts 0..PWM_DIV-1 and wraps. `pwm_tick` is asserted when `pwm_pre` = PWM_DIV-1.
- `pwm_cnt` is 8 bits. It increments on `pwm_tick` and wraps 255→0.

Per-channel duty (8 bits, saturating):
- On `ramp_tick`, if `ctrl_q[i]`=1 and duty<255: duty+1.
- On `ramp_tick`, if `ctrl_q[i]`=0 and duty>0: duty-1.
- Otherwise duty holds.
- A target reversal mid-ramp continues from the current duty value; there is no jump.
- `busy[i]` = (`ctrl_q[i]` ? duty≠255 : duty≠0). It is combinational from registers.

Output:
- level = duty (gamma mapping optional, see Configuration).
- `led[i]` is registered as: 1 if duty=255; 0 if duty=0; otherwise (`pwm_cnt` < level).
- duty=255 therefore gives solid on with no 1/256 glitch.

Reset:
- `ctrl_q`, all counters, all duty registers and `led` are cleared to 0.
- `busy` is therefore 0 out of reset.
- Reset mid-ramp drops duty to 0 immediately. After release, a channel whose `ctrl`=1 ramps up again from 0.

## Timing
- `ctrl` change → `ctrl_q`: 1 cycle.
- `ctrl` change → `busy` change: 1 cycle.
- `ctrl` change → first duty step: at the next `ramp_tick`, i.e. 1..RAMP_DIV cycles after `ctrl_q` updates.
- Full ramp 0→255 or 255→0: 255 ramp ticks = 255·RAMP_DIV cycles.
- `busy` deasserts in the cycle after the final duty step.
- Duty → `led`: 1 cycle (registered compare).
- PWM period: 256·PWM_DIV cycles. High time per period is level·PWM_DIV cycles for 0<duty<255.
- `ramp_tick` and `pwm_tick` in the same cycle: both take effect. The compare in that cycle uses the pre-update duty and `pwm_cnt`.
- All channels step on the same `ramp_tick`.

## Configuration
Macro: `PIO_LED_DRIVER_GAMMA_EN`.
- Defined: level = (duty·duty) >> 8, giving a perceptual fade. duty=255 and duty=0 keep their solid on/off override.
- Undefined: level = duty (linear). No multiplier is instantiated.

## Structure
Package `pio_led_driver_pkg` holds:
- `DUTY_W`=8 and `DUTY_MAX`=255.
- A `duty_t` typedef.
- The gamma function.

Sub-module `pio_led_channel` (one instance per channel) contains:
- Inputs: `ctrl_q` bit, `ramp_tick`, `pwm_cnt`.
- Duty register, saturating ramp logic, gamma/level mapping, compare, and the `led`/`busy` bit.

The top level contains the input register, both prescalers, `pwm_cnt` and the generate loop.

## Test plan
Bench settings: RAMP_DIV=4, PWM_DIV=1, gamma off unless stated.
- Reset release with `ctrl`=0000 → `led`=0000 and `busy`=0000 held for 2000 cycles.
- `ctrl`=0001 → `busy[0]`=1 one cycle later. Duty reaches 255 after 255 ramp ticks (≤1024 cycles). `busy[0]` then drops and `led[0]` stays solid 1. `led[3:1]`=0 throughout.
- `ctrl`=0001 for 100 ramp ticks, then `ctrl`=0000 → duty falls from 100 to 0 in exactly 100 ticks. `led[0]`=0 solid after the fall.
- Hold `ctrl[1]` until duty=64, then force hold (test hook or timed reversal) → `led[1]` high for 64 of every 256 cycles.
- Gamma on, duty=128 → level 64, so `led` is high 64/256 cycles. Duty=255 → solid on.
- Assert `reset_n`=0 mid-ramp at duty≈150 → `led` and `busy` are 0 within the same cycle. After release with `ctrl`=1111, all channels ramp from 0 together.
